lcd_floor_writer: RTL

LCD_FLOOR_WRITER -- requirements
Module: lcd_floor_writer

---
 rtl/smartlift_pkg.sv | 98 +++++++++
 rtl/lcd_byte_tx.sv | 97 +++++++++
 rtl/lcd_floor_writer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/smartlift_pkg.sv
// Shared constants, state types and character helpers for the lift LCD writer.
// The optional second display line is enabled with `define LCD_LINE2_EN.
package smartlift_pkg;

    localparam logic [7:0] LCD_CMD_FUNCSET = 8'h38;
    localparam logic [7:0] LCD_CMD_DISP_ON = 8'h0C;
    localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
    localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;
    localparam logic [7:0] LCD_CMD_LINE1   = 8'h80;
    localparam logic [7:0] LCD_CMD_LINE2   = 8'hC0;

    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_DASH  = 8'h2D;
    localparam logic [7:0] ASC_ZERO  = 8'h30;
    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_QMARK = 8'h3F;
    localparam logic [7:0] ASC_A     = 8'h41;
    localparam logic [7:0] ASC_D     = 8'h44;
    localparam logic [7:0] ASC_E     = 8'h45;
    localparam logic [7:0] ASC_I     = 8'h49;
    localparam logic [7:0] ASC_L     = 8'h4C;
    localparam logic [7:0] ASC_N     = 8'h4E;
    localparam logic [7:0] ASC_O     = 8'h4F;
    localparam logic [7:0] ASC_R     = 8'h52;
    localparam logic [7:0] ASC_S     = 8'h53;
    localparam logic [7:0] ASC_T     = 8'h54;
    localparam logic [7:0] ASC_U     = 8'h55;

    localparam int unsigned MAX_FLOOR = 8;

    typedef enum logic [2:0] {
        ST_PWRUP  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ADDR   = 3'd3,
        ST_CHARS  = 3'd4,
        ST_ADDR2  = 3'd5,
        ST_CHARS2 = 3'd6
    } lcd_state_e;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_SETUP = 2'd1,
        TX_PULSE = 2'd2,
        TX_WAIT  = 2'd3
    } tx_phase_e;

    function automatic logic [7:0] digit_to_ascii(input logic [3:0] v);
        if (v <= 4'(MAX_FLOOR)) return ASC_ZERO + {4'h0, v};
        return ASC_QMARK;
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return LCD_CMD_FUNCSET;
            2'd1:    return LCD_CMD_DISP_ON;
            2'd2:    return LCD_CMD_CLEAR;
            default: return LCD_CMD_ENTRY;
        endcase
    endfunction

    // "ANDAR ATUAL: n  "
    function automatic logic [7:0] line1_char(input logic [3:0] idx, input logic [3:0] floor);
        case (idx)
            4'd0:    return ASC_A;
            4'd1:    return ASC_N;
            4'd2:    return ASC_D;
            4'd3:    return ASC_A;
            4'd4:    return ASC_R;
            4'd6:    return ASC_A;
            4'd7:    return ASC_T;
            4'd8:    return ASC_U;
            4'd9:    return ASC_A;
            4'd10:   return ASC_L;
            4'd11:   return ASC_COLON;
            4'd13:   return digit_to_ascii(floor);
            default: return ASC_SPACE;
        endcase
    endfunction

    // "DESTINO: n      ", with '-' in place of n when no request is pending
    function automatic logic [7:0] line2_char(input logic [3:0] idx, input logic [3:0] dest,
                                              input logic valid);
        case (idx)
            4'd0:    return ASC_D;
            4'd1:    return ASC_E;
            4'd2:    return ASC_S;
            4'd3:    return ASC_T;
            4'd4:    return ASC_I;
            4'd5:    return ASC_N;
            4'd6:    return ASC_O;
            4'd7:    return ASC_COLON;
            4'd9:    return valid ? digit_to_ascii(dest) : ASC_DASH;
            default: return ASC_SPACE;
        endcase
    endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// Single-byte HD44780 write engine: setup, enable strobe, then command settle wait.
// RS/DATA stay registered after the byte so the bus never changes under the wait.
module lcd_byte_tx
    import smartlift_pkg::*;
#(
    parameter int EN_PULSE_CYC   = 12,
    parameter int SETUP_CYC      = 2,
    parameter int CMD_WAIT_CYC   = 2500,
    parameter int CLEAR_WAIT_CYC = 100000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       rs_i,
    input  logic [7:0] data_i,
    output logic       rs_o,
    output logic [7:0] data_o,
    output logic       en_o,
    output logic       ready_o,
    output logic       done_o,
    output logic [1:0] phase_o
);

    tx_phase_e   phase_q, phase_d;
    logic [31:0] cnt_q, cnt_d;
    logic        rs_q, rs_d;
    logic [7:0]  data_q, data_d;
    logic [31:0] wait_last;

    assign wait_last = (!rs_q && data_q == LCD_CMD_CLEAR) ? 32'(CLEAR_WAIT_CYC - 1)
                                                          : 32'(CMD_WAIT_CYC - 1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q <= TX_IDLE;
            cnt_q   <= '0;
            rs_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        data_d  = data_q;
        case (phase_q)
            TX_IDLE: begin
                if (start_i) begin
                    phase_d = TX_SETUP;
                    cnt_d   = '0;
                    rs_d    = rs_i;
                    data_d  = data_i;
                end
            end
            TX_SETUP: begin
                if (cnt_q == 32'(SETUP_CYC - 1)) begin
                    phase_d = TX_PULSE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            TX_PULSE: begin
                if (cnt_q == 32'(EN_PULSE_CYC - 1)) begin
                    phase_d = TX_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                if (cnt_q == wait_last) begin
                    phase_d = TX_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
        endcase
    end

    always_comb begin
        rs_o    = rs_q;
        data_o  = data_q;
        en_o    = (phase_q == TX_PULSE);
        ready_o = (phase_q == TX_IDLE);
        done_o  = (phase_q == TX_WAIT) && (cnt_q == wait_last);
        phase_o = phase_q;
    end

endmodule

// File: rtl/lcd_floor_writer.sv
// Lift floor display writer: power-up wait, HD44780 init, then refreshes on input change.
// Define LCD_LINE2_EN to add the destination line (and let destination inputs trigger refreshes).
module lcd_floor_writer
    import smartlift_pkg::*;
#(
    parameter int EN_PULSE_CYC   = 12,
    parameter int SETUP_CYC      = 2,
    parameter int CMD_WAIT_CYC   = 2500,
    parameter int CLEAR_WAIT_CYC = 100000,
    parameter int POWERUP_CYC    = 1000000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [3:0] andar_atual,
    input  logic [3:0] andar_dest,
    input  logic       dest_valid,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       busy,
    output logic [2:0] dbg_state
);

    lcd_state_e  state_q, state_d;
    logic [31:0] pwr_cnt_q, pwr_cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  snap_atual_q, snap_atual_d;
    logic        refresh_req;

    logic        tx_start, tx_rs, tx_ready, tx_done;
    logic [7:0]  tx_data;
    logic [1:0]  tx_phase;

`ifdef LCD_LINE2_EN
    logic [3:0]  snap_dest_q, snap_dest_d;
    logic        snap_valid_q, snap_valid_d;

    assign refresh_req = {andar_atual, andar_dest, dest_valid}
                      != {snap_atual_q, snap_dest_q, snap_valid_q};

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            snap_dest_q  <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            snap_dest_q  <= snap_dest_d;
            snap_valid_q <= snap_valid_d;
        end
    end
`else
    logic unused_line2;

    // Destination is not shown, so it must not cause refreshes.
    assign unused_line2 = ^{andar_dest, dest_valid, tx_phase};
    assign refresh_req  = (andar_atual != snap_atual_q);
`endif

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= ST_PWRUP;
            pwr_cnt_q    <= '0;
            idx_q        <= '0;
            snap_atual_q <= '0;
        end else begin
            state_q      <= state_d;
            pwr_cnt_q    <= pwr_cnt_d;
            idx_q        <= idx_d;
            snap_atual_q <= snap_atual_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pwr_cnt_d    = pwr_cnt_q;
        idx_d        = idx_q;
        snap_atual_d = snap_atual_q;
`ifdef LCD_LINE2_EN
        snap_dest_d  = snap_dest_q;
        snap_valid_d = snap_valid_q;
`endif
        case (state_q)
            ST_PWRUP: begin
                if (pwr_cnt_q == 32'(POWERUP_CYC - 1)) begin
                    state_d   = ST_INIT;
                    pwr_cnt_d = '0;
                    idx_d     = '0;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + 32'd1;
                end
            end
            ST_INIT: begin
                if (tx_done) begin
                    if (idx_q == 4'd3) begin
                        state_d = ST_ADDR;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_IDLE: begin
                if (refresh_req) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                if (tx_done) begin
                    state_d = ST_CHARS;
                    idx_d   = '0;
                end
            end
            ST_CHARS: begin
                if (tx_done) begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd15) begin
`ifdef LCD_LINE2_EN
                        state_d = ST_ADDR2;
`else
                        state_d = ST_IDLE;
`endif
                        idx_d = '0;
                    end
                end
            end
`ifdef LCD_LINE2_EN
            ST_ADDR2: begin
                if (tx_done) begin
                    state_d = ST_CHARS2;
                    idx_d   = '0;
                end
            end
            ST_CHARS2: begin
                if (tx_done) begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd15) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end
                end
            end
`endif
            default: state_d = ST_PWRUP;
        endcase

        // Every refresh enters ADDR from INIT or IDLE; that is where the snapshot is taken.
        if (state_d == ST_ADDR && state_q != ST_ADDR) begin
            snap_atual_d = andar_atual;
`ifdef LCD_LINE2_EN
            snap_dest_d  = andar_dest;
            snap_valid_d = dest_valid;
`endif
        end
    end

    always_comb begin
        tx_rs    = 1'b0;
        tx_data  = 8'h00;
        tx_start = 1'b0;
        case (state_q)
            ST_INIT: begin
                tx_data  = init_cmd(idx_q[1:0]);
                tx_start = tx_ready;
            end
            ST_ADDR: begin
                tx_data  = LCD_CMD_LINE1;
                tx_start = tx_ready;
            end
            ST_CHARS: begin
                tx_rs    = 1'b1;
                tx_data  = line1_char(idx_q, snap_atual_q);
                tx_start = tx_ready;
            end
`ifdef LCD_LINE2_EN
            ST_ADDR2: begin
                tx_data  = LCD_CMD_LINE2;
                tx_start = tx_ready;
            end
            ST_CHARS2: begin
                tx_rs    = 1'b1;
                tx_data  = line2_char(idx_q, snap_dest_q, snap_valid_q);
                tx_start = tx_ready;
            end
`endif
            default: ;
        endcase
        busy      = reset || (state_q != ST_IDLE);
        LCD_RW    = 1'b0;
        dbg_state = state_q;
    end

    lcd_byte_tx #(
        .EN_PULSE_CYC  (EN_PULSE_CYC),
        .SETUP_CYC     (SETUP_CYC),
        .CMD_WAIT_CYC  (CMD_WAIT_CYC),
        .CLEAR_WAIT_CYC(CLEAR_WAIT_CYC)
    ) u_tx (
        .clk_i  (CLOCK_50),
        .rst_i  (reset),
        .start_i(tx_start),
        .rs_i   (tx_rs),
        .data_i (tx_data),
        .rs_o   (LCD_RS),
        .data_o (LCD_DATA),
        .en_o   (LCD_EN),
        .ready_o(tx_ready),
        .done_o (tx_done),
        .phase_o(tx_phase)
    );

endmodule
